// File: rtl/decode_pkg.sv
// Shared decode definitions: class codes, RV32 major opcodes and the decoded
// instruction payload carried from the combinational decoder to the stage.
// The immediate field is carried at the widest supported XLEN (64) and
// truncated by the consumer.
package decode_pkg;

  localparam int unsigned IMM_W = 64;

  localparam logic [3:0] CLS_ALU_R   = 4'd0;
  localparam logic [3:0] CLS_ALU_I   = 4'd1;
  localparam logic [3:0] CLS_LUI     = 4'd2;
  localparam logic [3:0] CLS_AUIPC   = 4'd3;
  localparam logic [3:0] CLS_JAL     = 4'd4;
  localparam logic [3:0] CLS_JALR    = 4'd5;
  localparam logic [3:0] CLS_BRANCH  = 4'd6;
  localparam logic [3:0] CLS_LOAD    = 4'd7;
  localparam logic [3:0] CLS_STORE   = 4'd8;
  localparam logic [3:0] CLS_CSR     = 4'd9;
  localparam logic [3:0] CLS_SYSTEM  = 4'd10;
  localparam logic [3:0] CLS_FENCE   = 4'd11;
  localparam logic [3:0] CLS_CUSTOM  = 4'd12;
  localparam logic [3:0] CLS_ILLEGAL = 4'd15;

  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_IMM     = 7'b0010011;
  localparam logic [6:0] OP_OP      = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OP_FENCE   = 7'b0001111;
  localparam logic [6:0] OP_CUSTOM0 = 7'b0001011;
  localparam logic [6:0] OP_CUSTOM3 = 7'b1111111;

  typedef struct packed {
    logic [3:0]       cls;
    logic [3:0]       fn;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [IMM_W-1:0] imm;
  } dec_t;

  // Sign-extend a 12-bit immediate to the payload width.
  function automatic logic [IMM_W-1:0] sext12(input logic [11:0] v);
    return {{(IMM_W-12){v[11]}}, v};
  endfunction

endpackage

// File: rtl/instr_decode_comb.sv
// Purely combinational RV32 instruction word -> dec_t decoder.
// Parameters: XLEN (32 or 64; selects the shift-immediate funct check).
// Ports: instr (32-bit word in), dec (decoded payload out).
// Build option: DECODE_CUSTOM_EN enables CUSTOM class for custom-0 and
// opcode 7'b1111111 (I-format immediate); otherwise both are ILLEGAL.
module instr_decode_comb
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [IMM_W-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;
  logic             sh_zero, sh_alt;
  logic [3:0]       cls;
  logic             alt;
  logic [IMM_W-1:0] imm;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign imm_i = sext12(instr[31:20]);
  assign imm_s = sext12({instr[31:25], instr[11:7]});
  assign imm_b = {{(IMM_W-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {{(IMM_W-32){instr[31]}}, instr[31:12], 12'b0};
  assign imm_j = {{(IMM_W-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_z = {{(IMM_W-12){1'b0}}, instr[31:20]};

  // RV64 shift amounts take instr[25], leaving a 6-bit function field.
  if (XLEN == 64) begin : g_sh64
    assign sh_zero = (instr[31:26] == 6'h00);
    assign sh_alt  = (instr[31:26] == 6'h10);
  end else begin : g_sh32
    assign sh_zero = (funct7 == 7'h00);
    assign sh_alt  = (funct7 == 7'h20);
  end

  // Classify; anything not explicitly accepted stays ILLEGAL (covers instr==0).
  always_comb begin
    cls = CLS_ILLEGAL;
    alt = 1'b0;
    imm = '0;
    if (instr[1:0] == 2'b11) begin
      case (opcode)
        OP_OP: begin
          if ((funct7 == 7'h00) ||
              ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5)))) begin
            cls = CLS_ALU_R;
            alt = instr[30];
          end
        end
        OP_IMM: begin
          if (funct3 == 3'd1) begin
            if (sh_zero) begin
              cls = CLS_ALU_I;
              alt = instr[30];
              imm = imm_i;
            end
          end else if (funct3 == 3'd5) begin
            if (sh_zero || sh_alt) begin
              cls = CLS_ALU_I;
              alt = instr[30];
              imm = imm_i;
            end
          end else begin
            cls = CLS_ALU_I;
            imm = imm_i;
          end
        end
        OP_LUI: begin
          cls = CLS_LUI;
          imm = imm_u;
        end
        OP_AUIPC: begin
          cls = CLS_AUIPC;
          imm = imm_u;
        end
        OP_JAL: begin
          cls = CLS_JAL;
          imm = imm_j;
        end
        OP_JALR: begin
          if (funct3 == 3'd0) begin
            cls = CLS_JALR;
            imm = imm_i;
          end
        end
        OP_BRANCH: begin
          if ((funct3 != 3'd2) && (funct3 != 3'd3)) begin
            cls = CLS_BRANCH;
            imm = imm_b;
          end
        end
        OP_LOAD: begin
          if ((funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7)) begin
            cls = CLS_LOAD;
            imm = imm_i;
          end
        end
        OP_STORE: begin
          if (funct3 <= 3'd2) begin
            cls = CLS_STORE;
            imm = imm_s;
          end
        end
        OP_SYSTEM: begin
          cls = (funct3 == 3'd0) ? CLS_SYSTEM : CLS_CSR;
          imm = imm_z;
        end
        OP_FENCE: begin
          cls = CLS_FENCE;
          imm = imm_i;
        end
`ifdef DECODE_CUSTOM_EN
        OP_CUSTOM0, OP_CUSTOM3: begin
          cls = CLS_CUSTOM;
          imm = imm_i;
        end
`endif
        default: ;
      endcase
    end

    dec.cls = cls;
    dec.fn  = (cls == CLS_ILLEGAL) ? 4'd0 : {alt, funct3};
    dec.rd  = instr[11:7];
    dec.rs1 = instr[19:15];
    dec.rs2 = instr[24:20];
    dec.imm = imm;
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered, FIFO-buffered RV32 decode stage between fetch and issue.
// Parameters: XLEN (immediate width), DEPTH (FIFO entries, power of two),
// PC_W (pc width).
// Ports: clk, rst (async active-high), flush; fetch side in_valid/in_ready/
// in_instr/in_pc; issue side out_valid/out_ready/out_pc/out_cls/out_fn/
// out_rd/out_rs1/out_rs2/out_imm; fill = FIFO occupancy.
// Build option: DECODE_CUSTOM_EN (see instr_decode_comb).
module instr_decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [PC_W-1:0]        in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc,
  output logic [3:0]             out_cls,
  output logic [3:0]             out_fn,
  output logic [4:0]             out_rd,
  output logic [4:0]             out_rs1,
  output logic [4:0]             out_rs2,
  output logic [XLEN-1:0]        out_imm,
  output logic [$clog2(DEPTH):0] fill
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = AW + 1;

  logic [PC_W-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic            full, empty, push, pop;
  dec_t            head_dec;

  assign full     = (fill == FW'(DEPTH));
  assign empty    = (fill == '0);
  // No bypass when full: a same-cycle pop does not open a slot.
  assign in_ready = !full && !flush;
  assign push     = in_valid && in_ready;
  assign pop      = !empty && (!out_valid || out_ready) && !flush;

  instr_decode_comb #(.XLEN(XLEN)) u_dec (
    .instr (instr_mem[rptr]),
    .dec   (head_dec)
  );

  // Upper immediate bits exist only for the widest XLEN.
  if (XLEN < IMM_W) begin : g_imm_trunc
    logic unused_imm_hi;
    assign unused_imm_hi = ^head_dec.imm[IMM_W-1:XLEN];
  end

  // FIFO storage; contents are qualified by fill, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wptr]    <= in_pc;
      instr_mem[wptr] <= in_instr;
    end
  end

  // Pointers, occupancy and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_cls   <= '0;
      out_fn    <= '0;
      out_rd    <= '0;
      out_rs1   <= '0;
      out_rs2   <= '0;
      out_imm   <= '0;
    end else if (flush) begin
      wptr      <= '0;
      rptr      <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   fill <= fill + FW'(1);
        2'b01:   fill <= fill - FW'(1);
        default: ;
      endcase
      if (pop) begin
        out_valid <= 1'b1;
        out_pc    <= pc_mem[rptr];
        out_cls   <= head_dec.cls;
        out_fn    <= head_dec.fn;
        out_rd    <= head_dec.rd;
        out_rs1   <= head_dec.rs1;
        out_rs2   <= head_dec.rs2;
        out_imm   <= head_dec.imm[XLEN-1:0];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Registered, queue-buffered RV32 instruction decode stage: the parametrised successor of the combinational `instruction_decoder`. It accepts fetched {pc, instruction} pairs over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It decodes the FIFO head and presents one decoded instruction per cycle in an output register with its own valid/ready handshake. It sits between fetch and issue and supports a pipeline flush.

## Interface
- `XLEN`, 32, immediate/data width (32 or 64; immediates sign-extend to XLEN)
- `DEPTH`, 4, FIFO entries (power of two, ≥2)
- `PC_W`, 32, program counter width
- `clk` in 1: clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `flush` in 1: discard all buffered and output-held instructions
- `in_valid` in 1: fetch offers an instruction
- `in_ready` out 1: stage can accept
- `in_instr` in 32: instruction word
- `in_pc` in PC_W: instruction address
- `out_valid` out 1: decoded instruction held
- `out_ready` in 1: consumer takes it
- `out_pc` out PC_W: pc of held instruction
- `out_cls` out 4: class code, see Operation
- `out_fn` out 4: {alt, funct3}
- `out_rd`, `out_rs1`, `out_rs2` out 5 each: register fields, raw
- `out_imm` out XLEN: decoded immediate
- `fill` out $clog2(DEPTH)+1: FIFO occupancy (excludes output register)

## Operation
- Class codes:
  - 0 ALU_R, 1 ALU_I, 2 LUI, 3 AUIPC, 4 JAL, 5 JALR, 6 BRANCH, 7 LOAD, 8 STORE
  - 9 CSR (funct3≠0), 10 SYSTEM (ECALL/EBREAK/MRET, funct3=0), 11 FENCE, 12 CUSTOM, 15 ILLEGAL
- `alt` = instr[30] for ALU_R and for ALU_I shifts (funct3 = 1 or 5); 0 otherwise.
- Immediate by format:
  - I, S, B, J: sign-extended.
  - U: {instr[31:12], 12'b0}, sign-extended.
  - CSR and SYSTEM: csr address instr[31:20], zero-extended.
  - ALU_R: 0.
- ILLEGAL when any of:
  - instr[1:0]≠2'b11
  - unknown opcode
  - instr==0
  - ALU_R funct7 ∉ {0x00,0x20}, or 0x20 with funct3 ∉ {0,5}
  - shift-immediate funct7 invalid
  - BRANCH funct3 ∈ {2,3}
  - LOAD funct3 ∈ {3,6,7}
  - STORE funct3 > 2
  - JALR funct3≠0
- On ILLEGAL, register fields still pass through, `out_fn`=0 and `out_imm`=0.
- FIFO push when `in_valid & in_ready`.
- The output register loads the decoded FIFO head when the FIFO is non-empty and (`!out_valid` or `out_ready`). That pop is the FIFO pop.
- `in_ready` = `!full & !flush`. Combinational; no bypass when full, even if a pop happens in the same cycle.
- Push and pop in the same cycle leave `fill` unchanged. Pointers wrap modulo DEPTH.
- `flush`: on the next edge, `fill`←0, pointers←0, `out_valid`←0. `out_ready` is ignored during the flush cycle.
- Reset values:
  - `out_valid`, `out_pc`, `out_cls`, `out_fn`, `out_rd`, `out_rs1`, `out_rs2`, `out_imm`, `fill`: all 0.
  - `in_ready`=1 after reset.
  - Reset mid-operation drops all contents immediately (asynchronous).

## Timing
- Latency: an instruction accepted at edge N, with the FIFO empty and the output register free, appears with `out_valid`=1 after edge N+1.
- Throughput: 1 instruction/cycle sustained when `out_ready`=1.
- Output fields are stable while `out_valid & !out_ready`.
- Capacity: DEPTH+1 instructions in flight (FIFO + output register).

## Configuration
- `DECODE_CUSTOM_EN` defined: opcodes 7'b0001011 (custom-0) and 7'b1111111 decode as CUSTOM (12), with I-format immediate.
- Not defined: both opcodes decode as ILLEGAL (15).

## Structure
- Shared package `decode_pkg`: class code localparams, opcode localparams, and the `dec_t` struct {cls, fn, rd, rs1, rs2, imm}.
- Sub-module `instr_decode_comb`: purely combinational word→`dec_t` decode, parametrised by XLEN, instantiated on the FIFO head.
- Top: FIFO storage, pointers, occupancy counter, output register.

## Test plan
- Basic decode: push 0x00000797 → cls 3, rd 15, imm 0. Push 0x02c78793 → cls 1, rd 15, rs1 15, imm 44.
- Control flow:
  - 0x1a5000ef → cls 4, rd 1, imm 0x9A4.
  - 0x04079263 → cls 6, fn 1, rs1 15, rs2 0, imm 0x44.
- System and illegal:
  - 0x30200073 → cls 10, imm 0x302.
  - 0x00000000 → cls 15, imm 0.
  - 0x8000007F → cls 12 with `DECODE_CUSTOM_EN`, 15 without.
- Backpressure: hold `out_ready`=0 and push continuously → exactly DEPTH+1=5 accepted, `in_ready`=0, `fill`=4. Then raise `out_ready` → five outputs in push order, one per cycle.
- Flush: with 3 buffered and `out_valid`=1, pulse `flush` → next cycle `out_valid`=0, `fill`=0. `in_valid` during the flush cycle is not accepted.
- Reset mid-stream: assert `rst` between edges while full → outputs clear immediately, `in_ready`=1 after release, first subsequent push has 1-cycle latency.
